regfile_wb_queue: RTL and testbench



---
 rtl/regfile_wb_queue.sv | 131 +++++++++++++
 tb/tb_regfile_wb_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// Write-back queue owning the register file's single write port. It buffers ALU and
// load results in order, retires one per cycle, and redirects r15 writes to the PC.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [ADDR_W-1:0] alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              write_enable_o,
  output logic [ADDR_W-1:0] write_addr_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic              pc_load_o,
  output logic [DATA_W-1:0] pc_data_o,
  output logic [15:0]       pending_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(15);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] mem_slot;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free;

  logic alu_acc, mem_acc, pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic head_is_pc;

  // Ready looks only at the registered count, so a pop in the same cycle gives no credit.
  assign free        = CNT_W'(DEPTH) - count_q;
  assign alu_ready_o = (free != '0);
  assign mem_ready_o = (free >= CNT_W'(2)) || ((free != '0) && !alu_valid_i);

  assign alu_acc = alu_valid_i && alu_ready_o && !flush_i;
  assign mem_acc = mem_valid_i && mem_ready_o && !flush_i;
  assign pop     = (count_q != '0);

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mem_slot = wr_ptr_q + PTR_W'(alu_acc);
    wr_ptr_d = wr_ptr_q + PTR_W'(alu_acc) + PTR_W'(mem_acc);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(alu_acc) + CNT_W'(mem_acc) - CNT_W'(pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (flush_i) begin
        valid_q <= '0;
      end else begin
        if (pop)     valid_q[rd_ptr_q] <= 1'b0;
        if (alu_acc) valid_q[wr_ptr_q] <= 1'b1;
        if (mem_acc) valid_q[mem_slot] <= 1'b1;
      end
    end
  end

  // NOTE: payload storage has no reset; valid_q and the count qualify every read of it.
  always_ff @(posedge clk_i) begin
    if (alu_acc) begin
      addr_q[wr_ptr_q] <= alu_addr_i;
      data_q[wr_ptr_q] <= alu_data_i;
    end
    if (mem_acc) begin
      addr_q[mem_slot] <= mem_addr_i;
      data_q[mem_slot] <= mem_data_i;
    end
  end

  // Head is retired every non-empty cycle; outputs are zeroed when idle so nothing stale leaks out.
  assign head_addr  = addr_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];
  assign head_is_pc = (head_addr == PC_ADDR);

  assign write_enable_o = pop && !head_is_pc;
  assign write_addr_o   = write_enable_o ? head_addr : '0;
  assign write_data_o   = write_enable_o ? head_data : '0;
  assign pc_load_o      = pop && head_is_pc;
  assign pc_data_o      = pc_load_o ? head_data : '0;

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pending_o[addr_q[i]] = 1'b1;
    end
  end

  a_count_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_d <= CNT_W'(DEPTH));
  a_accept_fits: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (CNT_W'(alu_acc) + CNT_W'(mem_acc)) <= free);
  a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q == '0) |-> (count_d <= CNT_W'(2)));

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: each task drives one scenario and checks
// hand-computed retire order, pending mask and handshake values.
module tb_regfile_wb_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        alu_valid_i, mem_valid_i;
  logic        alu_ready_o, mem_ready_o;
  logic [3:0]  alu_addr_i, mem_addr_i;
  logic [31:0] alu_data_i, mem_data_i;
  logic        write_enable_o, pc_load_o, full_o, empty_o;
  logic [3:0]  write_addr_o;
  logic [31:0] write_data_o, pc_data_o;
  logic [15:0] pending_o;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .write_enable_o(write_enable_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o),
    .pc_load_o(pc_load_o), .pc_data_o(pc_data_o), .pending_o(pending_o),
    .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  // Move to just after the next rising edge; inputs change here, checks follow a settle delay.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid_i = 1'b0; mem_valid_i = 1'b0; flush_i = 1'b0;
    alu_addr_i = '0; alu_data_i = '0; mem_addr_i = '0; mem_data_i = '0;
  endtask

  task automatic drive(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [3:0] ma, input logic [31:0] md);
    alu_valid_i = av; alu_addr_i = aa; alu_data_i = ad;
    mem_valid_i = mv; mem_addr_i = ma; mem_data_i = md;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #2;
    n_checks++; if (write_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", write_enable_o); end
    n_checks++; if (pc_load_o !== 1'b0) begin n_fail++; $display("FAIL reset_pc_load: got %b want 0", pc_load_o); end
    n_checks++; if (pending_o !== 16'h0000) begin n_fail++; $display("FAIL reset_pending: got %h want 0000", pending_o); end
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty_o); end
    n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full_o); end
    n_checks++; if (alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_alu_ready: got %b want 1", alu_ready_o); end
    n_checks++; if (mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready: got %b want 1", mem_ready_o); end
    n_checks++; if (write_addr_o !== 4'h0 || write_data_o !== 32'h0 || pc_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got addr %h data %h pc %h want 0", write_addr_o, write_data_o, pc_data_o); end
    #11 rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_single_write();
    drive(1'b1, 4'd3, 32'h0000_00AA, 1'b0, 4'd0, 32'h0);
    #1;
    n_checks++; if (alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_alu_ready: got %b want 1", alu_ready_o); end
    cyc();
    idle_inputs();
    #1;
    n_checks++; if (write_enable_o !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", write_enable_o); end
    n_checks++; if (write_addr_o !== 4'd3) begin n_fail++; $display("FAIL single_addr: got %0d want 3", write_addr_o); end
    n_checks++; if (write_data_o !== 32'h0000_00AA) begin n_fail++; $display("FAIL single_data: got %h want 000000aa", write_data_o); end
    n_checks++; if (pending_o !== 16'h0008) begin n_fail++; $display("FAIL single_pending: got %h want 0008", pending_o); end
    cyc();
    #1;
    n_checks++; if (write_enable_o !== 1'b0) begin n_fail++; $display("FAIL single_we_after: got %b want 0", write_enable_o); end
    n_checks++; if (pending_o !== 16'h0000) begin n_fail++; $display("FAIL single_pending_after: got %h want 0000", pending_o); end
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL single_empty_after: got %b want 1", empty_o); end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
    #1;
    n_checks++; if (mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL pair_mem_ready: got %b want 1", mem_ready_o); end
    cyc();
    idle_inputs();
    #1;
    n_checks++; if (pending_o !== 16'h0006) begin n_fail++; $display("FAIL pair_pending0: got %h want 0006", pending_o); end
    n_checks++; if (write_enable_o !== 1'b1 || write_addr_o !== 4'd1 || write_data_o !== 32'h11) begin n_fail++; $display("FAIL pair_first: got we %b addr %0d data %h want 1 1 00000011", write_enable_o, write_addr_o, write_data_o); end
    cyc();
    #1;
    n_checks++; if (pending_o !== 16'h0004) begin n_fail++; $display("FAIL pair_pending1: got %h want 0004", pending_o); end
    n_checks++; if (write_enable_o !== 1'b1 || write_addr_o !== 4'd2 || write_data_o !== 32'h22) begin n_fail++; $display("FAIL pair_second: got we %b addr %0d data %h want 1 2 00000022", write_enable_o, write_addr_o, write_data_o); end
    cyc();
    #1;
    n_checks++; if (pending_o !== 16'h0000 || write_enable_o !== 1'b0) begin n_fail++; $display("FAIL pair_done: got pending %h we %b want 0000 0", pending_o, write_enable_o); end
  endtask

  // Retire is unconditional, so the queue peaks at three entries; at that level mem must back off.
  task automatic test_fill_and_drain();
    drive(1'b1, 4'd4, 32'h40, 1'b1, 4'd5, 32'h50);
    cyc();
    drive(1'b1, 4'd6, 32'h60, 1'b1, 4'd7, 32'h70);
    #1;
    n_checks++; if (mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_mem_ready_free2: got %b want 1", mem_ready_o); end
    n_checks++; if (write_addr_o !== 4'd4 || write_data_o !== 32'h40) begin n_fail++; $display("FAIL fill_head0: got addr %0d data %h want 4 00000040", write_addr_o, write_data_o); end
    cyc();
    drive(1'b1, 4'd8, 32'h80, 1'b1, 4'd9, 32'h90);
    #1;
    n_checks++; if (alu_ready_o !== 1'b1 || mem_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_ready_count3: got alu %b mem %b want 1 0", alu_ready_o, mem_ready_o); end
    n_checks++; if (full_o !== 1'b0 || empty_o !== 1'b0) begin n_fail++; $display("FAIL fill_flags_count3: got full %b empty %b want 0 0", full_o, empty_o); end
    n_checks++; if (pending_o !== 16'h00E0) begin n_fail++; $display("FAIL fill_pending_count3: got %h want 00e0", pending_o); end
    n_checks++; if (write_addr_o !== 4'd5 || write_data_o !== 32'h50) begin n_fail++; $display("FAIL fill_head1: got addr %0d data %h want 5 00000050", write_addr_o, write_data_o); end
    cyc();
    idle_inputs();
    #1;
    n_checks++; if (pending_o !== 16'h01C0) begin n_fail++; $display("FAIL fill_pending_mem_dropped: got %h want 01c0", pending_o); end
    n_checks++; if (write_addr_o !== 4'd6 || write_data_o !== 32'h60) begin n_fail++; $display("FAIL fill_head2: got addr %0d data %h want 6 00000060", write_addr_o, write_data_o); end
    cyc();
    #1;
    n_checks++; if (write_addr_o !== 4'd7 || write_data_o !== 32'h70) begin n_fail++; $display("FAIL fill_head3: got addr %0d data %h want 7 00000070", write_addr_o, write_data_o); end
    cyc();
    #1;
    n_checks++; if (write_addr_o !== 4'd8 || write_data_o !== 32'h80 || pending_o !== 16'h0100) begin n_fail++; $display("FAIL fill_head4: got addr %0d data %h pending %h want 8 00000080 0100", write_addr_o, write_data_o, pending_o); end
    cyc();
    #1;
    n_checks++; if (empty_o !== 1'b1 || write_enable_o !== 1'b0 || pending_o !== 16'h0000) begin n_fail++; $display("FAIL fill_drained: got empty %b we %b pending %h want 1 0 0000", empty_o, write_enable_o, pending_o); end
  endtask

  task automatic test_pc_load();
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 32'h0000_1000);
    cyc();
    idle_inputs();
    #1;
    n_checks++; if (pc_load_o !== 1'b1) begin n_fail++; $display("FAIL pc_load: got %b want 1", pc_load_o); end
    n_checks++; if (pc_data_o !== 32'h0000_1000) begin n_fail++; $display("FAIL pc_data: got %h want 00001000", pc_data_o); end
    n_checks++; if (write_enable_o !== 1'b0) begin n_fail++; $display("FAIL pc_we_blocked: got %b want 0", write_enable_o); end
    n_checks++; if (pending_o !== 16'h8000) begin n_fail++; $display("FAIL pc_pending: got %h want 8000", pending_o); end
    cyc();
    #1;
    n_checks++; if (pc_load_o !== 1'b0 || pending_o !== 16'h0000) begin n_fail++; $display("FAIL pc_after: got pc_load %b pending %h want 0 0000", pc_load_o, pending_o); end
  endtask

  task automatic test_same_dest();
    drive(1'b1, 4'd3, 32'h1, 1'b1, 4'd3, 32'h2);
    cyc();
    idle_inputs();
    #1;
    n_checks++; if (write_data_o !== 32'h1 || pending_o !== 16'h0008) begin n_fail++; $display("FAIL dup_older: got data %h pending %h want 00000001 0008", write_data_o, pending_o); end
    cyc();
    #1;
    n_checks++; if (write_data_o !== 32'h2 || write_addr_o !== 4'd3 || pending_o !== 16'h0008) begin n_fail++; $display("FAIL dup_younger: got addr %0d data %h pending %h want 3 00000002 0008", write_addr_o, write_data_o, pending_o); end
    cyc();
    #1;
    n_checks++; if (pending_o !== 16'h0000) begin n_fail++; $display("FAIL dup_cleared: got %h want 0000", pending_o); end
  endtask

  task automatic load_three();
    drive(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hA2);
    cyc();
    drive(1'b1, 4'd3, 32'hA3, 1'b1, 4'd4, 32'hA4);
    cyc();
    idle_inputs();
  endtask

  task automatic test_flush();
    load_three();
    #1;
    n_checks++; if (pending_o !== 16'h001C) begin n_fail++; $display("FAIL flush_pending_before: got %h want 001c", pending_o); end
    flush_i = 1'b1;
    drive(1'b1, 4'd5, 32'h55, 1'b0, 4'd0, 32'h0);
    #1;
    n_checks++; if (write_enable_o !== 1'b1 || write_addr_o !== 4'd2 || write_data_o !== 32'hA2) begin n_fail++; $display("FAIL flush_head_commit: got we %b addr %0d data %h want 1 2 000000a2", write_enable_o, write_addr_o, write_data_o); end
    cyc();
    idle_inputs();
    #1;
    n_checks++; if (empty_o !== 1'b1 || pending_o !== 16'h0000 || write_enable_o !== 1'b0) begin n_fail++; $display("FAIL flush_after: got empty %b pending %h we %b want 1 0000 0", empty_o, pending_o, write_enable_o); end
    cyc();
    #1;
    n_checks++; if (write_enable_o !== 1'b0 || empty_o !== 1'b1) begin n_fail++; $display("FAIL flush_dropped_input: got we %b empty %b want 0 1", write_enable_o, empty_o); end
  endtask

  task automatic test_reset_midstream();
    int writes_after;
    load_three();
    #1 rst_ni = 1'b0;
    #0.5;
    n_checks++; if (empty_o !== 1'b1 || pending_o !== 16'h0000 || write_enable_o !== 1'b0) begin n_fail++; $display("FAIL midreset_immediate: got empty %b pending %h we %b want 1 0000 0", empty_o, pending_o, write_enable_o); end
    #0.5 rst_ni = 1'b1;
    writes_after = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (write_enable_o === 1'b1 || pc_load_o === 1'b1) writes_after++;
    end
    n_checks++; if (writes_after !== 0) begin n_fail++; $display("FAIL midreset_no_writes: got %0d writes want 0", writes_after); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_fill_and_drain();
    test_pc_load();
    test_same_dest();
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
